// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the block-memory port controller.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_RESP    = 3'd3,
        ST_VFY_RD  = 3'd4,
        ST_VFY_CHK = 3'd5
    } state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch/data grant logic. Data normally wins; fetch is forced through after
// STARVE_MAX consecutive data grants taken while fetch was waiting.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_valid,
    input  logic dm_valid,
    input  logic accept_ok,
    output logic grant_if,
    output logic grant_dm
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             if_forced;

    always_comb begin
        if_forced    = (starve_cnt_q == CNT_W'(STARVE_MAX));
        grant_if     = accept_ok && if_valid && (!dm_valid || if_forced);
        grant_dm     = accept_ok && dm_valid && !grant_if;
        starve_cnt_d = starve_cnt_q;
        // Cannot pass STARVE_MAX: at the limit a waiting fetch takes the grant.
        if (grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_dm && if_valid) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rsta_n_unused_guard(rst_n)) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    function automatic logic rsta_n_unused_guard(input logic r);
        return r;
    endfunction

endmodule

// File: rtl/mem_port_ctrl.sv
// Initiator side of a single-port block memory shared by the fetch (if_*) and
// data (dm_*) requesters. Define MEM_WR_VERIFY_EN to read back and check every write.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    input  logic              dm_valid,
    output logic              dm_ready,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_rvalid,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta,
    output logic              wr_err,
    output logic [ADDR_W-1:0] err_addr
);

    // Handshake: a request transfers on a rising edge where valid && ready.
    // The requester holds address/data while valid && !ready; ready is a
    // function of valid and controller state, and at most one ready is high.

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic              owner_q, owner_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;

    logic              accept_ok;
    logic              grant_if;
    logic              grant_dm;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;

`ifdef MEM_WR_VERIFY_EN
    logic              wr_err_q, wr_err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // Writes are followed by a read-back, so no request is taken in WR.
    assign accept_ok = (state_q == ST_IDLE) || (state_q == ST_RESP);
`else
    assign accept_ok = (state_q == ST_IDLE) || (state_q == ST_WR) || (state_q == ST_RESP);
`endif

    mem_port_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clka),
        .rst_n     (rsta_n),
        .if_valid  (if_valid),
        .dm_valid  (dm_valid),
        .accept_ok (accept_ok),
        .grant_if  (grant_if),
        .grant_dm  (grant_dm)
    );

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        owner_d   = owner_q;
        wea_d     = 1'b0;
        addra_d   = addra_q;
        dina_d    = dina_q;
        req_we    = grant_dm && dm_we;
        req_addr  = grant_dm ? dm_addr : if_addr;
`ifdef MEM_WR_VERIFY_EN
        wr_err_d   = wr_err_q;
        err_addr_d = err_addr_q;
`endif

        case (state_q)
            ST_RD: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
`ifdef MEM_WR_VERIFY_EN
            ST_WR: begin
                state_d   = ST_VFY_RD;
                lat_cnt_d = LAT_LOAD;
            end
            ST_VFY_RD: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d = ST_VFY_CHK;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            ST_VFY_CHK: begin
                state_d = ST_IDLE;
                // dina_q still holds the written word; only the first bad address is kept.
                if (douta != dina_q) begin
                    wr_err_d = 1'b1;
                    if (!wr_err_q) begin
                        err_addr_d = addra_q;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (grant_if || grant_dm) begin
            addra_d   = req_addr;
            lat_cnt_d = LAT_LOAD;
            if (req_we) begin
                state_d = ST_WR;
                wea_d   = 1'b1;
                dina_d  = dm_wdata;
            end else begin
                state_d = ST_RD;
                owner_d = grant_dm ? PORT_DM : PORT_IF;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= 2'd0;
            owner_q    <= PORT_IF;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
`ifdef MEM_WR_VERIFY_EN
            wr_err_q   <= 1'b0;
            err_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            owner_q    <= owner_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
`ifdef MEM_WR_VERIFY_EN
            wr_err_q   <= wr_err_d;
            err_addr_q <= err_addr_d;
`endif
        end
    end

    assign if_ready  = grant_if;
    assign dm_ready  = grant_dm;
    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign if_rdata  = douta;
    assign dm_rdata  = douta;
    assign if_rvalid = (state_q == ST_RESP) && (owner_q == PORT_IF);
    assign dm_rvalid = (state_q == ST_RESP) && (owner_q == PORT_DM);

`ifdef MEM_WR_VERIFY_EN
    assign wr_err   = wr_err_q;
    assign err_addr = err_addr_q;
`else
    assign wr_err   = 1'b0;
    assign err_addr = '0;
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl (RD_LAT=1 main instance, RD_LAT=3 latency instance).
// Exercises the MEM_WR_VERIFY_EN read-back path when that macro is defined.
module tb_mem_port_ctrl;

    localparam int AW      = 10;
    localparam int DW      = 16;
    localparam int RD_LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RD_LAT=1)
    logic          rsta_n = 1'b0;
    logic          if_valid = 1'b0, dm_valid = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          if_ready, dm_ready, if_rvalid, dm_rvalid, wea, wr_err;
    logic [DW-1:0] if_rdata, dm_rdata, dina, douta;
    logic [AW-1:0] addra, err_addr;
    logic          corrupt = 1'b0;

    // Latency instance (RD_LAT=3), fetch side only
    logic          if2_valid = 1'b0, dm2_valid = 1'b0, dm2_we = 1'b0;
    logic [AW-1:0] if2_addr = '0, dm2_addr = '0;
    logic [DW-1:0] dm2_wdata = '0;
    logic          if2_ready, dm2_ready, if2_rvalid, dm2_rvalid, wea2, wr_err2;
    logic [DW-1:0] if2_rdata, dm2_rdata, dina2, douta2;
    logic [AW-1:0] addra2, err_addr2;

    mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT1), .STARVE_MAX(4)) u_dut (
        .clka(clk), .rsta_n(rsta_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .dm_valid(dm_valid), .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
        .wea(wea), .addra(addra), .dina(dina), .douta(douta),
        .wr_err(wr_err), .err_addr(err_addr)
    );

    mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(4)) u_dut_lat3 (
        .clka(clk), .rsta_n(rsta_n),
        .if_valid(if2_valid), .if_ready(if2_ready), .if_addr(if2_addr),
        .if_rdata(if2_rdata), .if_rvalid(if2_rvalid),
        .dm_valid(dm2_valid), .dm_ready(dm2_ready), .dm_we(dm2_we), .dm_addr(dm2_addr),
        .dm_wdata(dm2_wdata), .dm_rdata(dm2_rdata), .dm_rvalid(dm2_rvalid),
        .wea(wea2), .addra(addra2), .dina(dina2), .douta(douta2),
        .wr_err(wr_err2), .err_addr(err_addr2)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {6'b101001, a};
    endfunction

    // BRAM model, RD_LAT=1, read-first; unwritten words read as init_val
    logic [DW-1:0] mem1 [1024];
    bit   [1023:0] mem1_v;
    logic [DW-1:0] rd1_q;
    always @(posedge clk) begin
        rd1_q <= mem1_v[addra] ? mem1[addra] : init_val(addra);
        if (wea) begin
            mem1[addra]   <= dina;
            mem1_v[addra] <= 1'b1;
        end
    end
    assign douta = corrupt ? '0 : rd1_q;

    // BRAM model, RD_LAT=3, read-only
    logic [DW-1:0] p2 [3];
    always @(posedge clk) begin
        p2[0] <= init_val(addra2);
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign douta2 = p2[2];

    // Scoreboard state
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] dm_exp_q[$];
    logic [DW-1:0] if_exp_q[$];
    int            dm_cyc_q[$];
    int            if_cyc_q[$];
    int checks = 0, failures = 0, cyc = 0;
    int wea_cnt = 0, dmr_cnt = 0, dmrv_cnt = 0, ifrv_cnt = 0;

    // Sample at the falling edge and retire any returned read data.
    task automatic tick();
        logic [DW-1:0] e;
        int            c;
        @(negedge clk);
        cyc++;
        if (wea === 1'b1) wea_cnt++;
        if (dm_ready === 1'b1) dmr_cnt++;
        if (dm_rvalid === 1'b1) dmrv_cnt++;
        if (if_rvalid === 1'b1) ifrv_cnt++;
        if (if_ready === 1'b1 || dm_ready === 1'b1) begin
            checks++;
            if (if_ready === 1'b1 && dm_ready === 1'b1) begin
                failures++;
                $display("FAIL ready_exclusive cyc=%0d got if_ready=1 dm_ready=1 want at most one", cyc);
            end
        end
        if (dm_rvalid === 1'b1) begin
            checks++;
            if (dm_exp_q.size() == 0) begin
                failures++;
                $display("FAIL dm_rvalid_unexpected cyc=%0d got rvalid=1 want 0", cyc);
            end else begin
                e = dm_exp_q.pop_front();
                c = dm_cyc_q.pop_front();
                if (dm_rdata !== e || cyc - c != RD_LAT1 + 1) begin
                    failures++;
                    $display("FAIL dm_read got data=%h lat=%0d want data=%h lat=%0d",
                             dm_rdata, cyc - c, e, RD_LAT1 + 1);
                end
            end
        end
        if (if_rvalid === 1'b1) begin
            checks++;
            if (if_exp_q.size() == 0) begin
                failures++;
                $display("FAIL if_rvalid_unexpected cyc=%0d got rvalid=1 want 0", cyc);
            end else begin
                e = if_exp_q.pop_front();
                c = if_cyc_q.pop_front();
                if (if_rdata !== e || cyc - c != RD_LAT1 + 1) begin
                    failures++;
                    $display("FAIL if_read got data=%h lat=%0d want data=%h lat=%0d",
                             if_rdata, cyc - c, e, RD_LAT1 + 1);
                end
            end
        end
    endtask

    task automatic step();
        tick();
        @(posedge clk);
        #1;
    endtask

    // Drivers: raise valid, hold until ready, leave valid high for the caller.
    task automatic dm_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        dm_valid = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
        n = 0;
        tick();
        while (dm_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            tick();
            n++;
        end
        checks++;
        if (dm_ready !== 1'b1) begin
            failures++;
            $display("FAIL dm_req_timeout addr=%0d got ready=0 want 1", a);
        end else if (we) begin
            ref_mem[a] = d;
        end else begin
            dm_exp_q.push_back(ref_mem[a]);
            dm_cyc_q.push_back(cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic if_req(input logic [AW-1:0] a);
        int n;
        if_valid = 1'b1; if_addr = a;
        n = 0;
        tick();
        while (if_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            tick();
            n++;
        end
        checks++;
        if (if_ready !== 1'b1) begin
            failures++;
            $display("FAIL if_req_timeout addr=%0d got ready=0 want 1", a);
        end else begin
            if_exp_q.push_back(ref_mem[a]);
            if_cyc_q.push_back(cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rsta_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        tick();
        checks++;
        if ({wea, if_ready, dm_ready, if_rvalid, dm_rvalid, wr_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {wea, if_ready, dm_ready, if_rvalid, dm_rvalid, wr_err});
        end
        checks++;
        if (addra !== '0 || dina !== '0 || err_addr !== '0) begin
            failures++;
            $display("FAIL reset_bus got addra=%h dina=%h err_addr=%h want 0", addra, dina, err_addr);
        end
        checks++;
        if ({wea2, if2_ready, if2_rvalid, dm2_rvalid, wr_err2} !== 5'b0 || addra2 !== '0 || dina2 !== '0
            || err_addr2 !== '0) begin
            failures++;
            $display("FAIL reset_lat3 got wea=%b rvalid=%b addra=%h want 0", wea2, if2_rvalid, addra2);
        end
        rsta_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_if_read();
        if_req(10'd7);
        if_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (if_exp_q.size() != 0) begin
            failures++;
            $display("FAIL if_read_missing got pending=%0d want 0", if_exp_q.size());
        end
    endtask

    task automatic test_write_read();
        int w0, r0, i0;
        w0 = wea_cnt;
        dm_req(1'b1, 10'd5, 16'hBEEF);
        dm_valid = 1'b0;
        repeat (2) step();
        r0 = dmrv_cnt; i0 = ifrv_cnt;
        dm_req(1'b0, 10'd5, 16'h0000);
        dm_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (wea_cnt - w0 != 1) begin
            failures++;
            $display("FAIL wr_wea_cycles got %0d want 1", wea_cnt - w0);
        end
        checks++;
        if (dmrv_cnt - r0 != 1 || ifrv_cnt - i0 != 0) begin
            failures++;
            $display("FAIL wr_rd_rvalid got dm=%0d if=%0d want dm=1 if=0", dmrv_cnt - r0, ifrv_cnt - i0);
        end
        checks++;
        if (dm_exp_q.size() != 0) begin
            failures++;
            $display("FAIL wr_rd_missing got pending=%0d want 0", dm_exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int w0, r0, c_first, c_last;
        w0 = wea_cnt; r0 = dmr_cnt;
        c_first = 0; c_last = 0;
        for (int i = 0; i < 4; i++) begin
            dm_req(1'b1, AW'(i), DW'(16'h0010 + i));
            if (i == 0) c_first = cyc;
            c_last = cyc;
        end
        dm_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (wea_cnt - w0 != 4 || dmr_cnt - r0 != 4) begin
            failures++;
            $display("FAIL b2b_counts got wea=%0d ready=%0d want 4 4", wea_cnt - w0, dmr_cnt - r0);
        end
`ifndef MEM_WR_VERIFY_EN
        checks++;
        if (c_last - c_first != 3) begin
            failures++;
            $display("FAIL b2b_span got %0d cycles want 3", c_last - c_first);
        end
`endif
        for (int i = 0; i < 4; i++) dm_req(1'b0, AW'(i), '0);
        dm_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (dm_exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_readback_missing got pending=%0d want 0", dm_exp_q.size());
        end
    endtask

    task automatic test_reset_mid_read();
        int r0;
        r0 = dmrv_cnt;
        dm_req(1'b0, 10'd3, '0);
        dm_valid = 1'b0;
        rsta_n   = 1'b0;
        tick();
        dm_exp_q.delete();
        dm_cyc_q.delete();
        @(posedge clk); #1;
        rsta_n = 1'b1;
        tick();
        checks++;
        if (dm_rvalid !== 1'b0 || wea !== 1'b0 || if_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ctrl got dm_rvalid=%b wea=%b if_rvalid=%b want 0", dm_rvalid, wea, if_rvalid);
        end
        checks++;
        if (addra !== '0 || dina !== '0) begin
            failures++;
            $display("FAIL rst_mid_bus got addra=%h dina=%h want 0", addra, dina);
        end
        @(posedge clk); #1;
        repeat (4) step();
        checks++;
        if (dmrv_cnt != r0) begin
            failures++;
            $display("FAIL rst_mid_dropped got rvalids=%0d want 0", dmrv_cnt - r0);
        end
    endtask

    task automatic test_contention();
        int   k, n;
        logic exp_dm;
        if_valid = 1'b1; if_addr = 10'd20;
        dm_valid = 1'b1; dm_we = 1'b0; dm_addr = 10'd21;
        k = 0; n = 0;
        while (k < 10 && n < 100) begin
            tick();
            n++;
            if (if_ready === 1'b1 || dm_ready === 1'b1) begin
                exp_dm = (k % 5 != 4);
                checks++;
                if (dm_ready !== exp_dm) begin
                    failures++;
                    $display("FAIL contention_grant k=%0d got dm_ready=%b if_ready=%b want dm_ready=%b",
                             k, dm_ready, if_ready, exp_dm);
                end
                if (dm_ready === 1'b1) begin
                    dm_exp_q.push_back(ref_mem[21]);
                    dm_cyc_q.push_back(cyc);
                end else begin
                    if_exp_q.push_back(ref_mem[20]);
                    if_cyc_q.push_back(cyc);
                end
                k++;
            end
            @(posedge clk); #1;
        end
        if_valid = 1'b0; dm_valid = 1'b0;
        checks++;
        if (k != 10) begin
            failures++;
            $display("FAIL contention_timeout got grants=%0d want 10", k);
        end
        repeat (4) step();
        checks++;
        if (dm_exp_q.size() != 0 || if_exp_q.size() != 0) begin
            failures++;
            $display("FAIL contention_missing got dm=%0d if=%0d want 0 0", dm_exp_q.size(), if_exp_q.size());
        end
    endtask

    task automatic test_latency_rd3();
        int   a, n;
        logic seen;
        if2_valid = 1'b1; if2_addr = 10'd1;
        n = 0;
        tick();
        while (if2_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            tick();
            n++;
        end
        a = cyc;
        checks++;
        if (if2_ready !== 1'b1) begin
            failures++;
            $display("FAIL lat3_accept_timeout got ready=0 want 1");
        end
        @(posedge clk); #1;
        if2_valid = 1'b0;
        seen = 1'b0; n = 0;
        while (!seen && n < 12) begin
            tick();
            n++;
            if (if2_rvalid === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!seen || cyc - a != 4) begin
            failures++;
            $display("FAIL lat3_latency got seen=%b lat=%0d want 4", seen, cyc - a);
        end
        checks++;
        if (if2_rdata !== init_val(10'd1) || dm2_rdata !== if2_rdata) begin
            failures++;
            $display("FAIL lat3_data got if=%h dm=%h want %h", if2_rdata, dm2_rdata, init_val(10'd1));
        end
        @(posedge clk); #1;
        tick();
        checks++;
        if (if2_rvalid !== 1'b0 || dm2_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL lat3_pulse got if_rvalid=%b dm_rvalid=%b want 0 0", if2_rvalid, dm2_rvalid);
        end
        @(posedge clk); #1;
    endtask

`ifdef MEM_WR_VERIFY_EN
    task automatic test_verify();
        corrupt = 1'b1;
        dm_req(1'b1, 10'd9, 16'h1234);
        dm_valid = 1'b0;
        repeat (6) step();
        checks++;
        if (wr_err !== 1'b1 || err_addr !== 10'd9) begin
            failures++;
            $display("FAIL verify_first got wr_err=%b err_addr=%0d want 1 9", wr_err, err_addr);
        end
        dm_req(1'b1, 10'd12, 16'h5678);
        dm_valid = 1'b0;
        repeat (6) step();
        checks++;
        if (wr_err !== 1'b1 || err_addr !== 10'd9) begin
            failures++;
            $display("FAIL verify_sticky got wr_err=%b err_addr=%0d want 1 9", wr_err, err_addr);
        end
        corrupt = 1'b0;
    endtask
`else
    task automatic test_err_tied();
        checks++;
        if (wr_err !== 1'b0 || err_addr !== '0) begin
            failures++;
            $display("FAIL err_tied got wr_err=%b err_addr=%0d want 0 0", wr_err, err_addr);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(AW'(i));
        test_reset();
        test_if_read();
        test_write_read();
        test_back_to_back();
        test_reset_mid_read();
        test_contention();
        test_latency_rd3();
`ifdef MEM_WR_VERIFY_EN
        test_verify();
`else
        test_err_tied();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
